// File: rtl/rock_pkg.sv
// Shared definitions for the rocking-cradle control path: level width,
// level limits, controller states and small level arithmetic helpers.
package rock_pkg;

   localparam int             LEVEL_W       = 3;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX     = 3'd7;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN_RUN = 3'd1;
   localparam logic [LEVEL_W-1:0] LEVEL_OFF     = 3'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      RUN  = 2'd2,
      STOP = 2'd3
   } state_t;

   // Apply one Up/Down press to a target level. Up saturates at LEVEL_MAX,
   // Down saturates at LEVEL_MIN_RUN so a target can never request "off".
   // Both pressed together cancel out.
   function automatic logic [LEVEL_W-1:0] level_adjust(
      input logic [LEVEL_W-1:0] cur,
      input logic               up,
      input logic               dn
   );
      logic [LEVEL_W-1:0] res;
      res = cur;
      if (up && !dn) begin
         if (cur >= LEVEL_MAX) begin
            res = LEVEL_MAX;
         end else begin
            res = cur + 3'd1;
         end
      end else if (dn && !up) begin
         if (cur <= LEVEL_MIN_RUN) begin
            res = LEVEL_MIN_RUN;
         end else begin
            res = cur - 3'd1;
         end
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // Move a level one step toward its target (up or down), or hold it.
   function automatic logic [LEVEL_W-1:0] step_toward(
      input logic [LEVEL_W-1:0] cur,
      input logic [LEVEL_W-1:0] tgt
   );
      logic [LEVEL_W-1:0] res;
      if (cur < tgt) begin
         res = cur + 3'd1;
      end else if (cur > tgt) begin
         res = cur - 3'd1;
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // Move a level one step toward off, never below zero.
   function automatic logic [LEVEL_W-1:0] step_down(
      input logic [LEVEL_W-1:0] cur
   );
      logic [LEVEL_W-1:0] res;
      if (cur == LEVEL_OFF) begin
         res = LEVEL_OFF;
      end else begin
         res = cur - 3'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rock_setting_ctrl_if.sv
// Pushbutton inputs and level outputs of the cradle user-control stage.
// The slave side is the controller; the master side is whoever presses the
// buttons and consumes the levels.
interface rock_setting_ctrl_if;
   import rock_pkg::*;

   logic               btnFreqUp;
   logic               btnFreqDown;
   logic               btnAmpUp;
   logic               btnAmpDown;
   logic               btnStartStop;
   logic [LEVEL_W-1:0] Freq;
   logic [LEVEL_W-1:0] Amp;
   logic               Running;
   logic               Busy;

   modport master (
      output btnFreqUp,
      output btnFreqDown,
      output btnAmpUp,
      output btnAmpDown,
      output btnStartStop,
      input  Freq,
      input  Amp,
      input  Running,
      input  Busy
   );

   modport slave (
      input  btnFreqUp,
      input  btnFreqDown,
      input  btnAmpUp,
      input  btnAmpDown,
      input  btnStartStop,
      output Freq,
      output Amp,
      output Running,
      output Busy
   );

endinterface

// File: rtl/rock_setting_ctrl_button_debounce.sv
// One pushbutton channel: two-flop synchroniser, stability counter and a
// single-cycle press pulse on an accepted rising change. Releases are
// debounced the same way but produce no pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_r;
   logic             sync2_r;
   logic             stable_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Bring the asynchronous button level into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
      end
   end

   // Accept a level change only after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         stable_r <= 1'b0;
         press_r  <= 1'b0;
      end else if (sync2_r != stable_r) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            stable_r <= sync2_r;
            press_r  <= sync2_r;
         end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            press_r  <= 1'b0;
         end
      end else begin
         cnt_r   <= '0;
         press_r <= 1'b0;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/rock_setting_ctrl.sv
// Cradle user-control stage: debounced buttons set frequency/amplitude
// targets, and a small FSM walks the Freq/Amp outputs toward those targets
// (or toward zero when stopping) by at most one level per ramp tick.
module rock_setting_ctrl
   import rock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RAMP_CYCLES     = 25000000,
   parameter int START_FREQ      = 3,
   parameter int START_AMP       = 3
) (
   input  logic                 CLK,
   input  logic                 Reset,
   rock_setting_ctrl_if.slave   bus
);

   localparam int                   RAMP_W    = (RAMP_CYCLES > 2) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [RAMP_W-1:0]    RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
   localparam logic [RAMP_W-1:0]    RAMP_ONE  = RAMP_W'(1);
   localparam logic [LEVEL_W-1:0]   TGT_FREQ0 = LEVEL_W'(START_FREQ);
   localparam logic [LEVEL_W-1:0]   TGT_AMP0  = LEVEL_W'(START_AMP);

   logic               freq_up_s;
   logic               freq_dn_s;
   logic               amp_up_s;
   logic               amp_dn_s;
   logic               ss_press_s;
   logic               tick_s;
   logic               at_target_s;

   state_t             state_r;
   logic [LEVEL_W-1:0] freq_r;
   logic [LEVEL_W-1:0] amp_r;
   logic [LEVEL_W-1:0] tgt_freq_r;
   logic [LEVEL_W-1:0] tgt_amp_r;
   logic [RAMP_W-1:0]  ramp_cnt_r;
   logic               running_r;
   logic               busy_r;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freq_up (
      .clk(CLK), .rst_n(Reset), .raw(bus.btnFreqUp), .press(freq_up_s));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freq_dn (
      .clk(CLK), .rst_n(Reset), .raw(bus.btnFreqDown), .press(freq_dn_s));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_amp_up (
      .clk(CLK), .rst_n(Reset), .raw(bus.btnAmpUp), .press(amp_up_s));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_amp_dn (
      .clk(CLK), .rst_n(Reset), .raw(bus.btnAmpDown), .press(amp_dn_s));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clk(CLK), .rst_n(Reset), .raw(bus.btnStartStop), .press(ss_press_s));

   assign tick_s      = (ramp_cnt_r == RAMP_LAST);
   assign at_target_s = (freq_r == tgt_freq_r) && (amp_r == tgt_amp_r);

   // Targets follow the debounced Up/Down presses in every state.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         tgt_freq_r <= TGT_FREQ0;
         tgt_amp_r  <= TGT_AMP0;
      end else begin
         tgt_freq_r <= level_adjust(tgt_freq_r, freq_up_s, freq_dn_s);
         tgt_amp_r  <= level_adjust(tgt_amp_r, amp_up_s, amp_dn_s);
      end
   end

   // Motion FSM: state, ramp counter, output levels and status flags.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_r    <= IDLE;
         freq_r     <= LEVEL_OFF;
         amp_r      <= LEVEL_OFF;
         ramp_cnt_r <= '0;
         running_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               freq_r     <= LEVEL_OFF;
               amp_r      <= LEVEL_OFF;
               ramp_cnt_r <= '0;
               if (ss_press_s) begin
                  state_r   <= RAMP;
                  running_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  running_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            RAMP: begin
               if (ss_press_s) begin
                  state_r    <= STOP;
                  ramp_cnt_r <= '0;
                  running_r  <= 1'b0;
                  busy_r     <= 1'b1;
               end else if (at_target_s) begin
                  state_r    <= RUN;
                  ramp_cnt_r <= '0;
                  running_r  <= 1'b1;
                  busy_r     <= 1'b0;
               end else begin
                  state_r   <= RAMP;
                  running_r <= 1'b1;
                  busy_r    <= 1'b1;
                  if (tick_s) begin
                     ramp_cnt_r <= '0;
                     freq_r     <= step_toward(freq_r, tgt_freq_r);
                     amp_r      <= step_toward(amp_r, tgt_amp_r);
                  end else begin
                     ramp_cnt_r <= ramp_cnt_r + RAMP_ONE;
                  end
               end
            end
            RUN: begin
               ramp_cnt_r <= '0;
               if (ss_press_s) begin
                  state_r   <= STOP;
                  running_r <= 1'b0;
                  busy_r    <= 1'b1;
               end else if (!at_target_s) begin
                  // A target moved away from the held level: ramp to it.
                  state_r   <= RAMP;
                  running_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
                  busy_r    <= 1'b0;
               end
            end
            STOP: begin
               if (ss_press_s) begin
                  // Resume from the current levels; targets were never lost.
                  state_r    <= RAMP;
                  ramp_cnt_r <= '0;
                  running_r  <= 1'b1;
                  busy_r     <= 1'b1;
               end else if ((freq_r == LEVEL_OFF) && (amp_r == LEVEL_OFF)) begin
                  state_r    <= IDLE;
                  ramp_cnt_r <= '0;
                  running_r  <= 1'b0;
                  busy_r     <= 1'b0;
               end else begin
                  state_r   <= STOP;
                  running_r <= 1'b0;
                  busy_r    <= 1'b1;
                  if (tick_s) begin
                     ramp_cnt_r <= '0;
                     freq_r     <= step_down(freq_r);
                     amp_r      <= step_down(amp_r);
                  end else begin
                     ramp_cnt_r <= ramp_cnt_r + RAMP_ONE;
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               freq_r     <= LEVEL_OFF;
               amp_r      <= LEVEL_OFF;
               ramp_cnt_r <= '0;
               running_r  <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Freq    = freq_r;
   assign bus.Amp     = amp_r;
   assign bus.Running = running_r;
   assign bus.Busy    = busy_r;

endmodule

// File: tb/tb_rock_setting_ctrl.sv
// Directed bench for rock_setting_ctrl with DEBOUNCE_CYCLES=4, RAMP_CYCLES=8.
// All timing is counted in rising edges after an input change made 1 ns
// after an edge; outputs are sampled at the same point.
module tb_rock_setting_ctrl;
   import rock_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   int exp_freq [6] = '{3, 3, 4, 5, 6, 7};
   int exp_busy [6] = '{0, 1, 1, 1, 1, 1};

   rock_setting_ctrl_if bus ();

   rock_setting_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .RAMP_CYCLES    (8),
      .START_FREQ     (3),
      .START_AMP      (3)
   ) dut (
      .CLK  (clk),
      .Reset(reset_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      bus.btnFreqUp    = 1'b0;
      bus.btnFreqDown  = 1'b0;
      bus.btnAmpUp     = 1'b0;
      bus.btnAmpDown   = 1'b0;
      bus.btnStartStop = 1'b0;

      // Power-on reset
      cyc(3);
      chk("rst_freq", int'(bus.Freq), 0);
      chk("rst_amp", int'(bus.Amp), 0);
      chk("rst_running", int'(bus.Running), 0);
      chk("rst_busy", int'(bus.Busy), 0);
      reset_n = 1'b1;
      cyc(2);
      chk("rst_tgt_freq", int'(dut.tgt_freq_r), 3);
      chk("rst_tgt_amp", int'(dut.tgt_amp_r), 3);

      // Test 2: 3-cycle glitch is ignored
      bus.btnFreqUp = 1'b1;
      cyc(3);
      bus.btnFreqUp = 1'b0;
      cyc(12);
      chk("glitch_tgt_freq", int'(dut.tgt_freq_r), 3);

      // Held press: target changes on the 7th edge, exactly once
      bus.btnFreqUp = 1'b1;
      cyc(6);
      chk("press_early", int'(dut.tgt_freq_r), 3);
      cyc(1);
      chk("press_at7", int'(dut.tgt_freq_r), 4);
      cyc(3);
      bus.btnFreqUp = 1'b0;
      cyc(12);
      chk("press_once", int'(dut.tgt_freq_r), 4);

      // Back down to 3
      bus.btnFreqDown = 1'b1;
      cyc(7);
      chk("down_tgt_freq", int'(dut.tgt_freq_r), 3);
      cyc(3);
      bus.btnFreqDown = 1'b0;
      cyc(12);

      // Test 3: soft start from IDLE
      chk("idle_busy", int'(bus.Busy), 0);
      bus.btnStartStop = 1'b1;
      cyc(7);
      chk("start_running", int'(bus.Running), 1);
      chk("start_busy", int'(bus.Busy), 1);
      chk("start_freq0", int'(bus.Freq), 0);
      bus.btnStartStop = 1'b0;
      cyc(7);
      chk("start_freq_pre", int'(bus.Freq), 0);
      cyc(1);
      chk("start_freq1", int'(bus.Freq), 1);
      chk("start_amp1", int'(bus.Amp), 1);
      cyc(8);
      chk("start_freq2", int'(bus.Freq), 2);
      chk("start_amp2", int'(bus.Amp), 2);
      cyc(8);
      chk("start_freq3", int'(bus.Freq), 3);
      chk("start_amp3", int'(bus.Amp), 3);
      chk("start_busy_ramp", int'(bus.Busy), 1);
      cyc(1);
      chk("run_busy", int'(bus.Busy), 0);
      chk("run_running", int'(bus.Running), 1);

      // Test 4: six FreqUp presses, 8 cycles apart, while running
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("up_freq_%0d", i), int'(bus.Freq), exp_freq[i]);
         chk($sformatf("up_amp_%0d", i), int'(bus.Amp), 3);
         chk($sformatf("up_busy_%0d", i), int'(bus.Busy), exp_busy[i]);
         bus.btnFreqUp = 1'b1;
         cyc(4);
         bus.btnFreqUp = 1'b0;
         cyc(4);
      end
      chk("sat_tgt_freq", int'(dut.tgt_freq_r), 7);
      chk("sat_freq", int'(bus.Freq), 7);
      chk("sat_busy", int'(bus.Busy), 0);

      // Up and Down together cancel
      bus.btnFreqUp   = 1'b1;
      bus.btnFreqDown = 1'b1;
      cyc(4);
      bus.btnFreqUp   = 1'b0;
      bus.btnFreqDown = 1'b0;
      cyc(12);
      chk("both_tgt_freq", int'(dut.tgt_freq_r), 7);
      chk("both_busy", int'(bus.Busy), 0);

      // Test 5: soft stop from RUN at 7/3
      bus.btnStartStop = 1'b1;
      cyc(7);
      chk("stop_running", int'(bus.Running), 0);
      chk("stop_busy", int'(bus.Busy), 1);
      chk("stop_freq7", int'(bus.Freq), 7);
      bus.btnStartStop = 1'b0;
      cyc(24);
      chk("stop_amp0", int'(bus.Amp), 0);
      chk("stop_freq4", int'(bus.Freq), 4);
      cyc(32);
      chk("stop_freq0", int'(bus.Freq), 0);
      chk("stop_busy_last", int'(bus.Busy), 1);
      cyc(1);
      chk("idle_busy_end", int'(bus.Busy), 0);
      chk("idle_running_end", int'(bus.Running), 0);

      // Restart to 7/3
      bus.btnStartStop = 1'b1;
      cyc(7);
      bus.btnStartStop = 1'b0;
      cyc(57);
      chk("restart_freq", int'(bus.Freq), 7);
      chk("restart_amp", int'(bus.Amp), 3);
      chk("restart_busy", int'(bus.Busy), 0);

      // Test 6: resume during STOP at Freq=4
      bus.btnStartStop = 1'b1;
      cyc(7);
      bus.btnStartStop = 1'b0;
      cyc(24);
      chk("resume_pre_freq", int'(bus.Freq), 4);
      chk("resume_pre_amp", int'(bus.Amp), 0);
      bus.btnStartStop = 1'b1;
      cyc(7);
      chk("resume_running", int'(bus.Running), 1);
      chk("resume_busy", int'(bus.Busy), 1);
      chk("resume_freq4", int'(bus.Freq), 4);
      bus.btnStartStop = 1'b0;
      cyc(8);
      chk("resume_freq5", int'(bus.Freq), 5);
      chk("resume_amp1", int'(bus.Amp), 1);
      cyc(8);
      chk("resume_freq6", int'(bus.Freq), 6);
      chk("resume_amp2", int'(bus.Amp), 2);
      cyc(8);
      chk("resume_freq7", int'(bus.Freq), 7);
      chk("resume_amp3", int'(bus.Amp), 3);
      cyc(1);
      chk("resume_run_busy", int'(bus.Busy), 0);

      // Test 1: asynchronous reset mid-stop with Freq=5
      bus.btnStartStop = 1'b1;
      cyc(7);
      bus.btnStartStop = 1'b0;
      cyc(16);
      chk("pre_reset_freq", int'(bus.Freq), 5);
      reset_n = 1'b0;
      #1;
      chk("async_rst_freq", int'(bus.Freq), 0);
      chk("async_rst_amp", int'(bus.Amp), 0);
      chk("async_rst_running", int'(bus.Running), 0);
      chk("async_rst_busy", int'(bus.Busy), 0);
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      chk("post_rst_tgt_freq", int'(dut.tgt_freq_r), 3);
      chk("post_rst_tgt_amp", int'(dut.tgt_amp_r), 3);

      // AmpDown saturates at 1, never 0
      for (int i = 0; i < 3; i++) begin
         bus.btnAmpDown = 1'b1;
         cyc(7);
         chk($sformatf("amp_down_%0d", i), int'(dut.tgt_amp_r), (i == 0) ? 2 : 1);
         cyc(3);
         bus.btnAmpDown = 1'b0;
         cyc(10);
      end
      chk("amp_down_idle_busy", int'(bus.Busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
